jk_bank_cmd_arbiter: RTL and testbench

//  Shares a bank of NUM_FF external jk_ff flops among NUM_REQ requesters.
//  - Each requester issues one command (HOLD/RESET/SET/TOGGLE) for one flop index over a valid/ready handshake.
//  - A round-robin arbiter grants one requester at a time and drives the selected flop's j/k for one cycle.
//  - Returns the flop's post-update q to the winning requester.
//  - Sits between the control logic and the jk_ff bank. It is the only driver of the bank's j/k inputs.

---
 rtl/jk_cmd_pkg.sv | 10 +
 rtl/jk_bank_cmd_arbiter_rr.sv | 25 ++
 rtl/jk_bank_cmd_arbiter.sv | 70 +++++++
 tb/tb_jk_bank_cmd_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/jk_cmd_pkg.sv
// jk_cmd_pkg: jk command codes and arbiter FSM state encoding
package jk_cmd_pkg;
  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
endpackage

// File: rtl/jk_bank_cmd_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);
  logic [W-1:0] k;
  always_comb begin
    grant_idx = '0;
    any = 1'b0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(ptr) + i) % N);
      grant_idx = req[k] ? k : grant_idx;
      any = any | req[k];
    end
    grant = '0;
    grant[grant_idx] = any;
  end
endmodule

// File: rtl/jk_bank_cmd_arbiter.sv
// jk_bank_cmd_arbiter: round-robin command arbiter driving a shared jk_ff bank
module jk_bank_cmd_arbiter
  import jk_cmd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF  = 8,
  parameter int IDX_W   = $clog2(NUM_FF),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_cmd,
  input  logic [IDX_W*NUM_REQ-1:0] req_idx,
  output logic [NUM_FF-1:0]        ff_j,
  output logic [NUM_FF-1:0]        ff_k,
  input  logic [NUM_FF-1:0]        ff_q,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_q,
  output logic                     busy
);
  logic [1:0] state_q, state_d, cmd_q, cmd_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, grant_idx;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_REQ-1:0] grant;
  logic any, accept, issue, resp;
  rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .grant(grant),
    .grant_idx(grant_idx),
    .any(any)
  );
  always_comb begin
    accept = ~reset & (state_q == IDLE) & any;
    issue = ~reset & (state_q == ISSUE);
    resp = ~reset & (state_q == RESP);
    req_ready = accept ? grant : '0;
    ff_j = '0;
    ff_k = '0;
    ff_j[idx_q] = issue & cmd_q[1];
    ff_k[idx_q] = issue & cmd_q[0];
    rsp_valid = resp;
    rsp_id = resp ? id_q : '0;
    rsp_q = resp & ff_q[idx_q];
    busy = ~reset & (state_q != IDLE);
    state_d = accept ? ISSUE : (state_q == ISSUE) ? RESP : IDLE;
    ptr_d = !accept ? ptr_q : (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    cmd_d = accept ? req_cmd[2*grant_idx +: 2] : cmd_q;
    idx_d = accept ? req_idx[IDX_W*grant_idx +: IDX_W] : idx_q;
    id_d = accept ? grant_idx : id_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cmd_q <= '0;
      idx_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cmd_q <= cmd_d;
      idx_q <= idx_d;
      id_q <= id_d;
    end
  end
endmodule

// File: tb/tb_jk_bank_cmd_arbiter.sv
// tb_jk_bank_cmd_arbiter: randomized scoreboard bench with a jk_ff bank and reference model
module tb_jk_bank_cmd_arbiter;
  localparam int NR = 4;
  localparam int NF = 8;
  localparam int IW = 3;
  localparam int RW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [2*NR-1:0] req_cmd = '0;
  logic [IW*NR-1:0] req_idx = '0;
  logic [NF-1:0] ff_j, ff_k, ff_q;
  logic rsp_valid, rsp_q, busy;
  logic [RW-1:0] rsp_id;
  jk_bank_cmd_arbiter #(.NUM_REQ(NR), .NUM_FF(NF)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_idx(req_idx),
    .ff_j(ff_j),
    .ff_k(ff_k),
    .ff_q(ff_q),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_q(rsp_q),
    .busy(busy)
  );
  always_ff @(posedge clk) ff_q <= reset ? '0 : (ff_j & ~ff_q) | (~ff_k & ff_q);
  typedef struct {int id; bit q;} rsp_t;
  rsp_t exq[$];
  int n_vec = 0;
  int n_err = 0;
  bit pv[NR];
  logic [1:0] pc[NR];
  int pi[NR];
  bit m_acc[NR];
  int m_state = 0;
  int m_ptr = 0;
  int m_idx = 0;
  logic [1:0] m_cmd = 2'b00;
  bit [NF-1:0] m_bank = '0;
  bit rnd_mode = 0;
  bit fill_all = 0;
  bit post_rst = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic bit apply_cmd(logic [1:0] c, bit q);
    if (c == 2'b10) return 1'b1;
    if (c == 2'b01) return 1'b0;
    if (c == 2'b11) return ~q;
    return q;
  endfunction
  task automatic new_cmd(int r);
    pv[r] = 1'b1;
    pc[r] = 2'($urandom_range(0, 3));
    pi[r] = $urandom_range(0, NF - 1);
  endtask
  task automatic step();
    logic [NR-1:0] e_rdy;
    logic [NF-1:0] e_j, e_k;
    int g;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      if (m_acc[r]) begin
        pv[r] = 1'b0;
        if (fill_all) new_cmd(r);
      end
      m_acc[r] = 1'b0;
      if (rnd_mode && !pv[r] && $urandom_range(0, 2) == 0) new_cmd(r);
      req_valid[r] = pv[r];
      req_cmd[2*r +: 2] = pv[r] ? pc[r] : 2'($urandom_range(0, 3));
      req_idx[IW*r +: IW] = pv[r] ? IW'(pi[r]) : IW'($urandom_range(0, NF - 1));
    end
    #1;
    e_rdy = '0;
    e_j = '0;
    e_k = '0;
    if (post_rst) chk("ffq_after_reset", 32'(ff_q), 0);
    post_rst = 1'b0;
    chk("busy", 32'(busy), 32'(!reset && m_state != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(!reset && m_state == 2));
    if (reset) begin
      m_state = 0;
      m_ptr = 0;
      m_bank = '0;
      exq.delete();
      post_rst = 1'b1;
    end else if (m_state == 0) begin
      g = -1;
      for (int i = 0; i < NR; i++)
        if (g < 0 && pv[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        m_acc[g] = 1'b1;
        m_cmd = pc[g];
        m_idx = pi[g];
        m_bank[m_idx] = apply_cmd(m_cmd, m_bank[m_idx]);
        exq.push_back('{g, m_bank[m_idx]});
        m_ptr = (g + 1) % NR;
        m_state = 1;
      end
    end else if (m_state == 1) begin
      e_j[m_idx] = m_cmd[1];
      e_k[m_idx] = m_cmd[0];
      m_state = 2;
    end else m_state = 0;
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("ff_j", 32'(ff_j), 32'(e_j));
    chk("ff_k", 32'(ff_k), 32'(e_k));
  endtask
  always @(negedge clk) begin
    #2;
    if (rsp_valid) begin
      if (exq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        chk("rsp_id", 32'(rsp_id), 32'(exq[0].id));
        chk("rsp_q", 32'(rsp_q), 32'(exq[0].q));
        void'(exq.pop_front());
      end
    end
  end
  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      done = exq.size() == 0 && m_state == 0;
      for (int r = 0; r < NR; r++) done = done && !pv[r] && !m_acc[r];
      if (!done) step();
    end
    chk("drain_timeout", 32'(done), 1);
  endtask
  task automatic run(int r, logic [1:0] c, int idx);
    pv[r] = 1'b1;
    pc[r] = c;
    pi[r] = idx;
    drain();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask
  initial begin
    for (int r = 0; r < NR; r++) begin
      pv[r] = 1'b0;
      pc[r] = 2'b00;
      pi[r] = 0;
      m_acc[r] = 1'b0;
    end
    step();
    do_reset();
    run(0, 2'b10, 3);
    run(1, 2'b11, 3);
    run(1, 2'b11, 3);
    run(0, 2'b10, 5);
    run(2, 2'b00, 5);
    do_reset();
    for (int r = 0; r < NR; r++) new_cmd(r);
    fill_all = 1'b1;
    repeat (15) step();
    fill_all = 1'b0;
    drain();
    do_reset();
    pv[2] = 1'b1;
    pc[2] = 2'b10;
    pi[2] = 7;
    step();
    new_cmd(1);
    new_cmd(3);
    drain();
    pv[0] = 1'b1;
    pc[0] = 2'b10;
    pi[0] = 1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    run(3, 2'b11, 1);
    rnd_mode = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    rnd_mode = 1'b0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
